// File: rtl/frame_config_sequencer.sv
// Initiator of the frame-based fabric configuration protocol: assembles serial
// address+data frames and presents them to the decoder tree with setup/strobe/hold.
module frame_config_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned NUM_OUTPUTS = 29,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  bs_valid,
  input  logic                  bs_data,
  output logic                  bs_ready,
  output logic                  enable,
  output logic [0:ADDR_WIDTH-1] address,
  output logic                  data_out,
  output logic                  frame_err,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  busy
);

  localparam int unsigned BW = $clog2(ADDR_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(ADDR_WIDTH);

  typedef enum logic [1:0] {S_LOAD, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t                  r_state, w_state_nxt;
  logic [BW-1:0]           r_bit_cnt, w_bit_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   r_shadow, w_shadow_nxt;
  logic [0:ADDR_WIDTH-1]   r_address, w_address_nxt;
  logic                    r_data_out, w_data_out_nxt;
  logic                    r_bs_ready, w_bs_ready_nxt;
  logic                    r_enable, w_enable_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_frame_err, w_frame_err_nxt;
  logic [CNT_WIDTH-1:0]    r_frame_cnt, w_frame_cnt_nxt;
  logic [CNT_WIDTH-1:0]    r_err_cnt, w_err_cnt_nxt;
  logic                    w_xfer;
  logic                    w_in_range;

  assign w_xfer     = bs_valid & r_bs_ready;
  assign w_in_range = 32'(r_shadow) < NUM_OUTPUTS;

  // Next-state and next-output logic; all outputs are registered from these values
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shadow_nxt    = r_shadow;
    w_address_nxt   = r_address;
    w_data_out_nxt  = r_data_out;
    w_frame_err_nxt = r_frame_err;
    w_frame_cnt_nxt = r_frame_cnt;
    w_err_cnt_nxt   = r_err_cnt;

    case (r_state)
      S_LOAD: begin
        if (w_xfer) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_nxt = '0;
            if (w_in_range) begin
              w_state_nxt    = S_SETUP;
              w_data_out_nxt = bs_data;
              for (int i = 0; i < ADDR_WIDTH; i++) w_address_nxt[i] = r_shadow[i];
            end else begin
              w_frame_err_nxt = 1'b1;
              if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + CNT_WIDTH'(1);
            end
          end else begin
            for (int i = 0; i < ADDR_WIDTH; i++)
              if (BW'(i) == r_bit_cnt) w_shadow_nxt[i] = bs_data;
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          end
        end
      end
      S_SETUP:  w_state_nxt = S_STROBE;
      S_STROBE: w_state_nxt = S_HOLD;
      S_HOLD:   w_state_nxt = S_LOAD;
      default:  w_state_nxt = S_LOAD;
    endcase

    // Counted on entry to STROBE so the count is visible alongside enable
    if (w_state_nxt == S_STROBE && r_frame_cnt != '1)
      w_frame_cnt_nxt = r_frame_cnt + CNT_WIDTH'(1);

    w_enable_nxt   = (w_state_nxt == S_STROBE);
    w_bs_ready_nxt = (w_state_nxt == S_LOAD);
    w_busy_nxt     = (w_state_nxt != S_LOAD) || (w_bit_cnt_nxt != '0);
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_state     <= S_LOAD;
      r_bit_cnt   <= '0;
      r_shadow    <= '0;
      r_address   <= '0;
      r_data_out  <= 1'b0;
      r_bs_ready  <= 1'b1;
      r_enable    <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shadow    <= w_shadow_nxt;
      r_address   <= w_address_nxt;
      r_data_out  <= w_data_out_nxt;
      r_bs_ready  <= w_bs_ready_nxt;
      r_enable    <= w_enable_nxt;
      r_busy      <= w_busy_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign bs_ready  = r_bs_ready;
  assign enable    = r_enable;
  assign address   = r_address;
  assign data_out  = r_data_out;
  assign frame_err = r_frame_err;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
  assign busy      = r_busy;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed self-checking bench for frame_config_sequencer, with a second
// narrow-counter instance for saturation.
module tb_frame_config_sequencer;

  localparam int unsigned AW = 5;
  localparam int unsigned NO = 29;
  localparam int unsigned CW = 16;

  logic prog_clk   = 1'b0;
  logic prog_reset = 1'b0;
  logic bs_valid   = 1'b0;
  logic bs_data    = 1'b0;

  logic          bs_ready, enable, data_out, frame_err, busy;
  logic [0:AW-1] address;
  logic [CW-1:0] frame_cnt, err_cnt;

  logic          s_bs_ready, s_enable, s_data_out, s_frame_err, s_busy;
  logic [0:AW-1] s_address;
  logic [1:0]    s_frame_cnt, s_err_cnt;

  frame_config_sequencer #(.ADDR_WIDTH(AW), .NUM_OUTPUTS(NO), .CNT_WIDTH(CW)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .bs_valid(bs_valid), .bs_data(bs_data),
    .bs_ready(bs_ready), .enable(enable), .address(address), .data_out(data_out),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt), .busy(busy)
  );

  frame_config_sequencer #(.ADDR_WIDTH(AW), .NUM_OUTPUTS(NO), .CNT_WIDTH(2)) dut_sat (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .bs_valid(bs_valid), .bs_data(bs_data),
    .bs_ready(s_bs_ready), .enable(s_enable), .address(s_address), .data_out(s_data_out),
    .frame_err(s_frame_err), .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt), .busy(s_busy)
  );

  always #5 prog_clk = ~prog_clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge prog_clk) cyc <= cyc + 1;

  function automatic int addr_val(input logic [0:AW-1] a);
    int v;
    v = 0;
    for (int i = 0; i < AW; i++) if (a[i] === 1'b1) v = v | (1 << i);
    return v;
  endfunction

  // Log every enable pulse with its cycle, address and data bit
  int   en_cyc[$];
  int   en_addr[$];
  logic en_data[$];
  logic prev_en = 1'b0;
  int   consec  = 0;

  always @(negedge prog_clk) begin
    if (enable === 1'b1) begin
      en_cyc.push_back(cyc);
      en_addr.push_back(addr_val(address));
      en_data.push_back(data_out);
      if (prev_en === 1'b1) consec = consec + 1;
    end
    prev_en = enable;
  end

  task automatic clear_log();
    en_cyc.delete();
    en_addr.delete();
    en_data.delete();
  endtask

  task automatic apply_reset();
    @(negedge prog_clk);
    bs_valid   = 1'b0;
    bs_data    = 1'b0;
    prog_reset = 1'b1;
    @(negedge prog_clk);
    prog_reset = 1'b0;
    clear_log();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge prog_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    @(negedge prog_clk);
    while (bs_ready !== 1'b1 && n < 50) begin
      @(negedge prog_clk);
      n++;
    end
    if (bs_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_bit_timeout: bs_ready=%0b required 1", bs_ready);
    end
    bs_valid = 1'b1;
    bs_data  = b;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic send_frame(input int a, input logic d);
    logic [31:0] av;
    av = 32'(a);
    for (int i = 0; i < AW; i++) send_bit(av[i]);
    send_bit(d);
  endtask

  task automatic test_reset();
    #2 prog_reset = 1'b1;
    #3;
    checks++; if (bs_ready !== 1'b1)   begin errors++; $display("FAIL rst_bs_ready: got %0b want 1", bs_ready); end
    checks++; if (enable !== 1'b0)     begin errors++; $display("FAIL rst_enable: got %0b want 0", enable); end
    checks++; if (addr_val(address) !== 0 || data_out !== 1'b0) begin errors++; $display("FAIL rst_addr_data: got %0d/%0b want 0/0", addr_val(address), data_out); end
    checks++; if (frame_cnt !== '0 || err_cnt !== '0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_status: frame_cnt=%0d err_cnt=%0d frame_err=%0b busy=%0b want all 0", frame_cnt, err_cnt, frame_err, busy); end
    @(negedge prog_clk);
    prog_reset = 1'b0;
    // Drive a frame into STROBE, then reset between clock edges
    send_frame(5, 1'b1);
    bs_valid = 1'b0;
    @(negedge prog_clk);
    @(negedge prog_clk);
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL mid_strobe_enable: got %0b want 1", enable); end
    #2 prog_reset = 1'b1;
    #1;
    checks++; if (enable !== 1'b0 || bs_ready !== 1'b1) begin errors++; $display("FAIL midrst_en_ready: enable=%0b bs_ready=%0b want 0/1", enable, bs_ready); end
    checks++; if (frame_cnt !== '0 || err_cnt !== '0 || addr_val(address) !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_state: frame_cnt=%0d err_cnt=%0d addr=%0d busy=%0b want 0", frame_cnt, err_cnt, addr_val(address), busy); end
    @(negedge prog_clk);
    prog_reset = 1'b0;
    clear_log();
  endtask

  task automatic test_valid_frame();
    int c0;
    apply_reset();
    send_frame(3, 1'b1);
    c0 = cyc;
    bs_valid = 1'b0;
    @(negedge prog_clk);
    checks++; if (addr_val(address) !== 3 || data_out !== 1'b1) begin errors++; $display("FAIL valid_setup_addr: got %0d/%0b want 3/1", addr_val(address), data_out); end
    checks++; if (enable !== 1'b0 || bs_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL valid_setup_ctl: enable=%0b bs_ready=%0b busy=%0b want 0/0/1", enable, bs_ready, busy); end
    wait_cycles(4);
    checks++; if (en_cyc.size() !== 1) begin errors++; $display("FAIL valid_pulse_count: got %0d want 1", en_cyc.size()); end
    else begin
      checks++; if (en_cyc[0] !== c0 + 1) begin errors++; $display("FAIL valid_pulse_time: got cycle %0d want %0d", en_cyc[0], c0 + 1); end
      checks++; if (en_addr[0] !== 3 || en_data[0] !== 1'b1) begin errors++; $display("FAIL valid_pulse_addr: got %0d/%0b want 3/1", en_addr[0], en_data[0]); end
    end
    checks++; if (frame_cnt !== CW'(1)) begin errors++; $display("FAIL valid_frame_cnt: got %0d want 1", frame_cnt); end
    checks++; if (bs_ready !== 1'b1 || busy !== 1'b0 || addr_val(address) !== 3) begin
      errors++; $display("FAIL valid_after: bs_ready=%0b busy=%0b addr=%0d want 1/0/3", bs_ready, busy, addr_val(address)); end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    send_frame(30, 1'b0);
    bs_valid = 1'b0;
    wait_cycles(4);
    checks++; if (en_cyc.size() !== 0) begin errors++; $display("FAIL oor_no_enable: got %0d pulses want 0", en_cyc.size()); end
    checks++; if (frame_err !== 1'b1 || err_cnt !== CW'(1)) begin errors++; $display("FAIL oor_err: frame_err=%0b err_cnt=%0d want 1/1", frame_err, err_cnt); end
    checks++; if (addr_val(address) !== 0 || bs_ready !== 1'b1 || busy !== 1'b0 || frame_cnt !== '0) begin
      errors++; $display("FAIL oor_state: addr=%0d bs_ready=%0b busy=%0b frame_cnt=%0d want 0/1/0/0", addr_val(address), bs_ready, busy, frame_cnt); end
    send_frame(28, 1'b1);
    bs_valid = 1'b0;
    wait_cycles(4);
    checks++; if (en_cyc.size() !== 1) begin errors++; $display("FAIL oor_next_count: got %0d want 1", en_cyc.size()); end
    else begin
      checks++; if (en_addr[0] !== 28 || en_data[0] !== 1'b1) begin errors++; $display("FAIL oor_next_addr: got %0d/%0b want 28/1", en_addr[0], en_data[0]); end
    end
    checks++; if (frame_cnt !== CW'(1) || frame_err !== 1'b1 || err_cnt !== CW'(1)) begin
      errors++; $display("FAIL oor_next_status: frame_cnt=%0d frame_err=%0b err_cnt=%0d want 1/1/1", frame_cnt, frame_err, err_cnt); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    consec = 0;
    for (int a = 0; a < int'(NO); a++) send_frame(a, a[0]);
    bs_valid = 1'b0;
    wait_cycles(5);
    checks++; if (en_cyc.size() !== int'(NO)) begin errors++; $display("FAIL b2b_count: got %0d want %0d", en_cyc.size(), NO); end
    else begin
      for (int i = 0; i < int'(NO); i++) begin
        checks++; if (en_addr[i] !== i || en_data[i] !== i[0]) begin errors++; $display("FAIL b2b_addr[%0d]: got %0d/%0b want %0d/%0b", i, en_addr[i], en_data[i], i, i[0]); end
        if (i > 0) begin
          checks++; if (en_cyc[i] - en_cyc[i-1] !== AW + 4) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, en_cyc[i] - en_cyc[i-1], AW + 4); end
        end
      end
    end
    checks++; if (frame_cnt !== CW'(NO)) begin errors++; $display("FAIL b2b_frame_cnt: got %0d want %0d", frame_cnt, NO); end
    checks++; if (consec !== 0) begin errors++; $display("FAIL b2b_consecutive_enable: got %0d want 0", consec); end
  endtask

  task automatic test_stall();
    int bad;
    apply_reset();
    // Address 19 = 1,1,0,0,1 LSB first; stall after three bits
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    bs_valid = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge prog_clk);
      bs_data = ~bs_data;
      if (busy !== 1'b1 || enable !== 1'b0 || addr_val(address) !== 0 || bs_ready !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold: %0d bad cycles want 0", bad); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bs_valid = 1'b0;
    wait_cycles(4);
    checks++; if (en_cyc.size() !== 1) begin errors++; $display("FAIL stall_count: got %0d want 1", en_cyc.size()); end
    else begin
      checks++; if (en_addr[0] !== 19 || en_data[0] !== 1'b0) begin errors++; $display("FAIL stall_addr: got %0d/%0b want 19/0", en_addr[0], en_data[0]); end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 1; k <= 5; k++) send_frame(k, 1'b0);
    bs_valid = 1'b0;
    wait_cycles(4);
    checks++; if (s_frame_cnt !== 2'd3) begin errors++; $display("FAIL sat_frame_cnt: got %0d want 3", s_frame_cnt); end
    checks++; if (frame_cnt !== CW'(5) || en_cyc.size() !== 5) begin errors++; $display("FAIL sat_ref_count: frame_cnt=%0d pulses=%0d want 5/5", frame_cnt, en_cyc.size()); end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_out_of_range();
    test_back_to_back();
    test_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
